seg_scan_ctrl: RTL
==================

Name: seg_scan_ctrl

Overview:
- Time-multiplexes the shared active-low 7-segment bus across 4 digit anodes for the signed adder result display.
- Advances one digit per scan_tick pulse from the clock divider.
- Inserts a blanking gap on every digit switch to prevent ghosting.
- Double-buffers the displayed value so updates land only on frame boundaries (no tearing).
- Applies optional leading-zero suppression.

Parameters:
- BLANK_CYC, 2, clk cycles with all anodes off after each digit switch; legal range is 1 or more.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- scan_tick  in  1  single-cycle enable; request to advance to the next digit
- load  in  1  single-cycle strobe; capture data_in into the pending buffer
- data_in  in  16  four 4-bit digit codes; [3:0] is digit0 (rightmost), [15:12] is digit3
- lz_en  in  1  leading-zero suppression enable
- an  out  4  digit anodes, active low, an[i] selects digit i
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- cur_dig  out  2  index of the digit currently selected
- frame_done  out  1  one-cycle pulse when digit3's slot ends
- load_ack  out  1  one-cycle pulse when pending data moves to the display register

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state:
  - state=BLANK, cur_dig=0, blank counter=0
  - an=4'b1111, seg=7'h7F
  - disp=16'hFFFF, pend=0
  - frame_done=0, load_ack=0
- A reset asserted mid-frame discards pending data; no ack is issued.
- All outputs are registered and change on the same edge as the state register.
- BLANK state:
  - an=1111, seg=7F.
  - The counter increments each clk.
  - When counter==BLANK_CYC-1, the next edge enters DRIVE and resets the counter.
  - All anodes are therefore off for exactly BLANK_CYC cycles.
- DRIVE state:
  - an[cur_dig]=0, all other anodes 1.
  - seg = decode of the effective code for cur_dig.
- scan_tick in DRIVE:
  - Next edge: state=BLANK and cur_dig increments, wrapping 3 to 0.
  - If cur_dig was 3: frame_done pulses.
  - If cur_dig was 3 and pend=1: disp<=pending, pend<=0, load_ack pulses in the same cycle.
- scan_tick in BLANK is ignored and not queued. Integration requires scan_tick period > BLANK_CYC+1.
- Load handling:
  - load sets pending<=data_in and pend<=1.
  - With multiple loads before a boundary, the last one wins.
  - A load in the same cycle as a transfer: the old pending value is transferred, the new value is captured, and pend stays 1.
- Decode:
  - 0..9 map to standard patterns; 0=1000000, 2=0100100, 7=1111000.
  - A = minus, 0111111.
  - B..F = blank, 1111111.
- Leading-zero suppression (lz_en=1):
  - A digit i≥1 with code 0 is treated as blank when every higher digit code is 0 or blank (B..F).
  - Minus counts as non-zero.
  - Digit0 is never suppressed.
  - Suppression is evaluated on disp, combinationally feeding the seg register.
- A suppressed or blank digit still asserts its anode during its slot; seg=7F.

Test Plan:
- Reset: rst=1 for 2 cycles -> an=1111, seg=7F, load_ack=0. After release with BLANK_CYC=2: exactly 2 cycles later an=1110, seg=7F.
- lz_en=0, load 16'h0127, scan_tick every 8 clks:
  - load_ack pulses once, coincident with frame_done.
  - Next frame: digit0 seg=1111000, digit1=0100100, digit2=1111001, digit3=1000000.
- lz_en=1, data 16'h0007 -> digits 3..1 have anodes asserted with seg=7F; digit0=1111000. Data 16'h0000 -> only digit0 shows 1000000.
- lz_en=1, data 16'hFA05 -> digit3 blank, digit2 0111111, digit1 1000000, digit0 0010010.
- Buffering:
  - Loads 16'h1111 then 16'h2222 in one frame -> one load_ack, then 2222 is displayed.
  - A load of 16'h3333 in the same cycle as a transfer -> 2222 is shown that frame, and 3333 follows the next frame with a second load_ack.
- Robustness:
  - scan_tick during BLANK -> no cur_dig change and blank length unchanged.
  - rst mid-frame with pend=1 -> no load_ack, disp=FFFF, sequence restarts at digit0.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: drives a shared active-low 7-segment bus across 4 digit anodes.
// Each digit slot starts with a BLANK_CYC-cycle all-anodes-off gap, then drives
// until scan_tick. Displayed data is double-buffered and swapped only at the
// end of digit3's slot. Optional leading-zero suppression.
//
// Ports:
//   clk        - system clock
//   rst        - synchronous active-high reset
//   scan_tick  - single-cycle request to advance to the next digit
//   load       - single-cycle strobe, captures data_in into the pending buffer
//   data_in    - four 4-bit digit codes, [3:0] = digit0 (rightmost)
//   lz_en      - leading-zero suppression enable
//   an         - digit anodes, active low, an[i] selects digit i
//   seg        - segments {g,f,e,d,c,b,a}, active low
//   cur_dig    - index of the currently selected digit
//   frame_done - one-cycle pulse when digit3's slot ends
//   load_ack   - one-cycle pulse when pending data moves to the display register
module seg_scan_ctrl #(
  parameter int unsigned BLANK_CYC = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_tick,
  input  logic        load,
  input  logic [15:0] data_in,
  input  logic        lz_en,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic [1:0]  cur_dig,
  output logic        frame_done,
  output logic        load_ack
);

  localparam int unsigned CW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BLANK_CYC - 1);

  typedef enum logic {S_BLANK, S_DRIVE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [15:0]   disp;
  logic [15:0]   pending;
  logic          pend;
  logic [3:0]    eff_code [4];
  logic [6:0]    cur_seg;

  // Code 0..9 digits, A = minus, B..F = blank.
  function automatic logic [6:0] decode(input logic [3:0] code);
    case (code)
      4'h0:    decode = 7'b1000000;
      4'h1:    decode = 7'b1111001;
      4'h2:    decode = 7'b0100100;
      4'h3:    decode = 7'b0110000;
      4'h4:    decode = 7'b0011001;
      4'h5:    decode = 7'b0010010;
      4'h6:    decode = 7'b0000010;
      4'h7:    decode = 7'b1111000;
      4'h8:    decode = 7'b0000000;
      4'h9:    decode = 7'b0010000;
      4'hA:    decode = 7'b0111111;
      default: decode = 7'b1111111;
    endcase
  endfunction

  // Leading-zero suppression: scan from digit3 down; a zero stays blank while
  // everything above it is zero or blank. Minus breaks the run.
  always_comb begin : lz_blk
    logic       lead;
    logic [3:0] code;
    lead = 1'b1;
    code = 4'h0;
    for (int i = 3; i >= 0; i--) begin
      code = disp[4*i +: 4];
      if (i != 0 && lz_en && lead && code == 4'h0) eff_code[i] = 4'hF;
      else                                         eff_code[i] = code;
      lead = lead && (code == 4'h0 || code >= 4'hB);
    end
  end

  assign cur_seg = decode(eff_code[cur_dig]);

  // Scan FSM with registered outputs and display double buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_BLANK;
      cur_dig    <= 2'd0;
      cnt        <= '0;
      an         <= 4'b1111;
      seg        <= 7'h7F;
      disp       <= 16'hFFFF;
      pending    <= 16'h0000;
      pend       <= 1'b0;
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      load_ack   <= 1'b0;
      if (load) begin
        pending <= data_in;
        pend    <= 1'b1;
      end
      case (state)
        S_BLANK: begin
          an  <= 4'b1111;
          seg <= 7'h7F;
          if (cnt == CNT_LAST) begin
            state <= S_DRIVE;
            cnt   <= '0;
            an    <= ~(4'b0001 << cur_dig);
            seg   <= cur_seg;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_DRIVE: begin
          if (scan_tick) begin
            state   <= S_BLANK;
            cur_dig <= cur_dig + 2'd1;
            an      <= 4'b1111;
            seg     <= 7'h7F;
            if (cur_dig == 2'd3) begin
              frame_done <= 1'b1;
              // Frame boundary: swap in pending data; a same-cycle load keeps pend set.
              if (pend) begin
                disp     <= pending;
                load_ack <= 1'b1;
                if (!load) pend <= 1'b0;
              end
            end
          end else begin
            seg <= cur_seg;
          end
        end
        default: state <= S_BLANK;
      endcase
    end
  end

endmodule
